// File: rtl/elevator_pkg.sv
// Shared constants and FSM state type for the elevator request queue.
package elevator_pkg;

    localparam int unsigned LVL_W       = 2;
    localparam int unsigned QUEUE_DEPTH = 4;
    localparam int unsigned QUEUE_W     = LVL_W * QUEUE_DEPTH;
    localparam int unsigned TAIL_W      = 3;

    localparam logic [LVL_W-1:0] LVL_A = 2'd0;
    localparam logic [LVL_W-1:0] LVL_B = 2'd1;
    localparam logic [LVL_W-1:0] LVL_C = 2'd2;
    localparam logic [LVL_W-1:0] LVL_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

endpackage

// File: rtl/pressed_lvl_in_queue_logic.sv
// Duplicate check: flags a level already held in the valid part of the queue.
//   i_lvl   : level being pressed
//   i_queue : registered queue, entry k at bits [2k+1:2k]
//   i_tail  : number of valid entries
//   o_hit_c : level found among entries 0..tail-1 (combinational)
module pressed_lvl_in_queue_logic
    import elevator_pkg::*;
(
    input  logic [LVL_W-1:0]   i_lvl,
    input  logic [QUEUE_W-1:0] i_queue,
    input  logic [TAIL_W-1:0]  i_tail,
    output logic               o_hit_c
);

    always_comb begin
        o_hit_c = 1'b0;
        for (int unsigned k = 0; k < QUEUE_DEPTH; k++) begin
            if ((TAIL_W'(k) < i_tail) && (i_queue[k*LVL_W +: LVL_W] == i_lvl)) begin
                o_hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_queue_ctrl.sv
// FIFO elevator sequencer: queues floor presses, moves the car one floor at a
// time toward the head request, opens the door on arrival and dequeues.
//   clk, rst_n  : clock, asynchronous active-low reset
//   press_valid : button press strobe; press_lvl the pressed floor
//   press_ready : queue not full (combinational from registered tail)
//   cur_lvl     : car floor; moving/dir_up travel status
//   door_open   : door open; arrived one-cycle pulse on head service
//   queue, tail : request FIFO contents (entry 0 = head) and fill count
module elevator_queue_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned FLOOR_TICKS = 8,
    parameter int unsigned DOOR_TICKS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               press_valid,
    input  logic [LVL_W-1:0]   press_lvl,
    output logic               press_ready,
    output logic [LVL_W-1:0]   cur_lvl,
    output logic               moving,
    output logic               dir_up,
    output logic               door_open,
    output logic               arrived,
    output logic [QUEUE_W-1:0] queue,
    output logic [TAIL_W-1:0]  tail
);

    localparam int unsigned CNT_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [LVL_W-1:0]   r_cur_lvl,   w_cur_lvl_nxt;
    logic               r_moving,    w_moving_nxt;
    logic               r_dir_up,    w_dir_up_nxt;
    logic               r_door_open, w_door_open_nxt;
    logic               r_arrived,   w_arrived_nxt;
    logic [QUEUE_W-1:0] r_queue,     w_queue_nxt;
    logic [TAIL_W-1:0]  r_tail,      w_tail_nxt;

    logic [LVL_W-1:0]   w_head;
    logic [LVL_W-1:0]   w_lvl_step;
    logic [TAIL_W-1:0]  w_push_idx;
    logic               w_deq;
    logic               w_dup;
    logic               w_push;

    assign w_head      = r_queue[LVL_W-1:0];
    assign w_lvl_step  = (r_state == ST_MOVE_UP) ? (r_cur_lvl + LVL_W'(1)) : (r_cur_lvl - LVL_W'(1));
    assign press_ready = (r_tail != TAIL_W'(QUEUE_DEPTH));
    assign w_push      = press_valid && press_ready && !w_dup;

    // Duplicate check always sees the pre-shift queue.
    pressed_lvl_in_queue_logic u_dup (
        .i_lvl   (press_lvl),
        .i_queue (r_queue),
        .i_tail  (r_tail),
        .o_hit_c (w_dup)
    );

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cur_lvl_nxt   = r_cur_lvl;
        w_moving_nxt    = r_moving;
        w_dir_up_nxt    = r_dir_up;
        w_door_open_nxt = r_door_open;
        w_arrived_nxt   = 1'b0;
        w_deq           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_tail != '0) begin
                    w_cnt_nxt = '0;
                    if (w_head == r_cur_lvl) begin
                        w_state_nxt     = ST_DOOR_OPEN;
                        w_door_open_nxt = 1'b1;
                        w_arrived_nxt   = 1'b1;
                        w_deq           = 1'b1;
                    end else if (w_head > r_cur_lvl) begin
                        w_state_nxt  = ST_MOVE_UP;
                        w_moving_nxt = 1'b1;
                        w_dir_up_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_MOVE_DOWN;
                        w_moving_nxt = 1'b1;
                        w_dir_up_nxt = 1'b0;
                    end
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (r_cnt == FLOOR_LAST) begin
                    w_cnt_nxt     = '0;
                    w_cur_lvl_nxt = w_lvl_step;
                    if (w_lvl_step == w_head) begin
                        w_state_nxt     = ST_DOOR_OPEN;
                        w_moving_nxt    = 1'b0;
                        w_dir_up_nxt    = 1'b0;
                        w_door_open_nxt = 1'b1;
                        w_arrived_nxt   = 1'b1;
                        w_deq           = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (r_cnt == DOOR_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_cnt_nxt       = '0;
                    w_door_open_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Queue update: shift on dequeue, then append at the post-shift tail.
    always_comb begin
        w_queue_nxt = r_queue;
        w_tail_nxt  = r_tail;
        w_push_idx  = r_tail;
        if (w_deq) begin
            for (int unsigned k = 0; k < QUEUE_DEPTH - 1; k++) begin
                w_queue_nxt[k*LVL_W +: LVL_W] = r_queue[(k+1)*LVL_W +: LVL_W];
            end
            w_tail_nxt = r_tail - TAIL_W'(1);
            w_push_idx = r_tail - TAIL_W'(1);
        end
        if (w_push) begin
            for (int unsigned k = 0; k < QUEUE_DEPTH; k++) begin
                if (w_push_idx == TAIL_W'(k)) begin
                    w_queue_nxt[k*LVL_W +: LVL_W] = press_lvl;
                end
            end
            w_tail_nxt = w_tail_nxt + TAIL_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cur_lvl   <= LVL_A;
            r_moving    <= 1'b0;
            r_dir_up    <= 1'b0;
            r_door_open <= 1'b0;
            r_arrived   <= 1'b0;
            r_queue     <= '0;
            r_tail      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur_lvl   <= w_cur_lvl_nxt;
            r_moving    <= w_moving_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_door_open <= w_door_open_nxt;
            r_arrived   <= w_arrived_nxt;
            r_queue     <= w_queue_nxt;
            r_tail      <= w_tail_nxt;
        end
    end

    assign cur_lvl   = r_cur_lvl;
    assign moving    = r_moving;
    assign dir_up    = r_dir_up;
    assign door_open = r_door_open;
    assign arrived   = r_arrived;
    assign queue     = r_queue;
    assign tail      = r_tail;

endmodule

// File: doc/elevator_queue_ctrl.md
# elevator_queue_ctrl

Sequencer for the elevator request queue, serving 4 floors (A–D) with a 4-entry FIFO.
- Accepts floor-button presses and drops duplicates using the existing `pressed_lvl_in_queue_logic` block.
- Appends new requests at the tail and drives the car one floor at a time toward the queue head.
- Opens the door on arrival and dequeues the head by shifting the queue up.
- Sits between the button-input logic and the car/door actuators.

## Interface
Parameters:
- `FLOOR_TICKS`, default 8: cycles to travel one floor (≥1).
- `DOOR_TICKS`, default 4: cycles the door stays open (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `press_valid` in 1: button press strobe.
- `press_lvl` in 2: pressed floor (A=0, B=1, C=2, D=3).
- `press_ready` out 1: press is accepted when `press_valid && press_ready`.
- `cur_lvl` out 2: current car floor.
- `moving` out 1: car is travelling.
- `dir_up` out 1: 1 means travelling up; valid only while `moving`.
- `door_open` out 1: door is open.
- `arrived` out 1: one-cycle pulse when the head request is served.
- `queue` out 8: entry k occupies bits [2k+1:2k]; entry 0 is the head.
- `tail` out 3: number of valid entries, 0..4.

## Operation
- Reset values: state IDLE, `cur_lvl`=A, `queue`=0, `tail`=0, `moving`=0, `dir_up`=0, `door_open`=0, `arrived`=0, counter=0. `press_ready`=1.
- `press_ready` = (`tail` != 4), combinational from registered `tail`.
- Accepted press, duplicate (level in entries 0..tail-1 of the registered queue): dropped, queue unchanged.
- Accepted press, not a duplicate: written at index `tail`, `tail`+1.
- Dequeue: entry k ← entry k+1 for k=0..2. Entry 3 keeps its value (stale beyond tail). `tail`−1.
- Simultaneous dequeue and non-duplicate append: new level goes to index `tail`−1 after the shift. `tail` unchanged.
- Duplicate check always uses the pre-shift queue. A press equal to the head being dequeued is dropped.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE with `tail`=0: stay in IDLE.
- IDLE with `tail`>0, head == `cur_lvl`: go to DOOR_OPEN, dequeue, pulse `arrived`.
- IDLE with `tail`>0, head > `cur_lvl`: go to MOVE_UP.
- IDLE with `tail`>0, head < `cur_lvl`: go to MOVE_DOWN.
- MOVE_*:
  - Counter counts 0..FLOOR_TICKS−1. On the terminal count, `cur_lvl` ±1 and the counter clears.
  - If the new `cur_lvl` == head: go to DOOR_OPEN, dequeue, pulse `arrived`.
  - Otherwise stay in MOVE_* for the next floor.
- Service order is strict FIFO. Intermediate floors are not served en route.
- DOOR_OPEN: stays DOOR_TICKS cycles, then IDLE.
- `cur_lvl` never wraps. A move below A or above D is unreachable by construction.

## Timing
- All state, queue, tail and outputs are registered on the rising `clk` edge, except `press_ready`.
- An append is visible on `queue`/`tail` the cycle after acceptance.
- The IDLE decision uses registered `tail`/head. A press accepted at edge N can start `moving` at edge N+1 at the earliest.
- `moving` and `dir_up` are high for exactly FLOOR_TICKS × |head − cur_lvl| cycles.
- On the arrival edge, all of these happen together: `cur_lvl` updates, `moving` falls, `door_open` rises, `arrived` pulses, and the dequeue lands.
- `door_open` stays high exactly DOOR_TICKS cycles.
- `rst_n` low at any time forces all reset values immediately, mid-move or mid-door.

## Structure
- Shared `elevator_pkg` holds:
  - level constants A..D,
  - `QUEUE_DEPTH`=4 and `LVL_W`=2,
  - the FSM state enum.
- Counter width is $clog2(max(FLOOR_TICKS, DOOR_TICKS)+1).
- One sub-module: `pressed_lvl_in_queue_logic`, driven by `press_lvl`, registered `queue` and registered `tail`, for the duplicate check.

## Test plan
- Reset check: after reset, `cur_lvl`=0, `tail`=0, `door_open`=0, `moving`=0, `press_ready`=1.
- Single request (defaults): press D from idle at A.
  - `moving`=1 and `dir_up`=1 for 24 cycles; `cur_lvl` steps 1, 2, 3 at +8, +16, +24.
  - `arrived` pulses once, `door_open`=1 for 4 cycles, `tail` goes 1→0.
- Duplicate drop: press B, then press B again while moving → `tail` stays 1, `queue[1:0]`=B.
- Full queue: while at A with door open, press A, B, C, D → `tail`=4, `press_ready`=0. Further presses do not change the queue.
- Simultaneous events: queue {C, B}, tail=2; press D on the cycle the car arrives at C → `queue[3:0]`={D, B}, `tail`=2.
- Reset mid-move: assert `rst_n`=0 during MOVE_UP between floors → outputs return to reset values immediately, with no `arrived` pulse.
